// File: rtl/fp_pkg.sv
// Shared FP32 types and constants for the sequential multiplier (fp_mul_seq).
// Rounding mode is selected by FP_MUL_RNE_EN in fp_mul_seq.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } fp_state_e;

  // Signed zero or signed infinity, used for all special-case results.
  function automatic fp32_t fp_special(input logic sign, input logic inf);
    fp32_t r;
    r.sign = sign;
    r.exp  = inf ? 8'hFF : 8'h00;
    r.mant = '0;
    return r;
  endfunction

endpackage

// File: rtl/fp_mul_iter.sv
// Iterative 24x24 shift-add mantissa multiplier, RADIX_BITS multiplier bits per cycle.
// start loads the operands; done is high on the cycle whose edge retires the last digit.
module fp_mul_iter #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] mcand,
  input  logic [23:0] mplier,
  output logic        done,
  output logic [47:0] product
);

  localparam int N  = 24 / RADIX_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [47:0]   mcand_q,  mcand_d;
  logic [23:0]   mplier_q, mplier_d;
  logic [47:0]   acc_q,    acc_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          busy_q,   busy_d;
  logic [47:0]   partial;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    partial  = mcand_q * 48'(mplier_q[RADIX_BITS-1:0]);
    if (start) begin
      mcand_d  = {24'b0, mcand};
      mplier_d = mplier;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << RADIX_BITS;
      mplier_d = mplier_q >> RADIX_BITS;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) busy_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: pure datapath registers are left unreset; they are always loaded by start before use.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

  assign done    = busy_q && (cnt_q == CW'(N - 1));
  assign product = acc_q;

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential FP32 multiplier with valid/ready handshakes; subnormals flush to zero.
// Define FP_MUL_RNE_EN for round-to-nearest-even, otherwise the mantissa is truncated.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] opd1,
  input  logic [31:0] opd2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        overflow,
  output logic        underflow
);

  fp_state_e   state_q, state_d;
  fp32_t       opd1_q, opd1_d, opd2_q, opd2_d;
  fp32_t       res_q, res_d;
  logic        ovf_q, ovf_d, unf_q, unf_d;
  logic        start_q, start_d;
  logic        accept;
  logic        mul_done;
  logic [47:0] prod;

  // Multiplier is kicked off one cycle after accept, from the registered operands.
  fp_mul_iter #(.RADIX_BITS(RADIX_BITS)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (start_q),
    .mcand   ({1'b1, opd1_q.mant}),
    .mplier  ({1'b1, opd2_q.mant}),
    .done    (mul_done),
    .product (prod)
  );

  logic signed [9:0] exp_sum, exp_norm, exp_rnd;
  logic [22:0]       mant_norm, mant_rnd;
  logic              g_bit, s_bit, round_up, res_sign;
  fp32_t             norm_res;
  logic              norm_ovf, norm_unf;

  always_comb begin
    exp_sum  = $signed({2'b00, opd1_q.exp}) + $signed({2'b00, opd2_q.exp})
             - $signed(10'(FP_BIAS));
    res_sign = opd1_q.sign ^ opd2_q.sign;
    if (prod[47]) begin
      mant_norm = prod[46:24];
      g_bit     = prod[23];
      s_bit     = |prod[22:0];
      exp_norm  = exp_sum + 10'sd1;
    end else begin
      mant_norm = prod[45:23];
      g_bit     = prod[22];
      s_bit     = |prod[21:0];
      exp_norm  = exp_sum;
    end
  end

`ifdef FP_MUL_RNE_EN
  assign round_up = g_bit & (s_bit | mant_norm[0]);
`else
  logic unused_round_bits;
  assign unused_round_bits = g_bit ^ s_bit;
  assign round_up          = 1'b0;
`endif

  always_comb begin
    mant_rnd = mant_norm + 23'(round_up);
    exp_rnd  = exp_norm;
    // Mantissa wrap on round-up renormalises to 1.0 x 2^(e+1).
    if (round_up && (&mant_norm)) exp_rnd = exp_norm + 10'sd1;

    norm_res = '{sign: res_sign, exp: exp_rnd[7:0], mant: mant_rnd};
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    if ((opd1_q.exp == 8'hFF) || (opd2_q.exp == 8'hFF)) begin
      norm_res = fp_special(res_sign, 1'b1);
      norm_ovf = 1'b1;
    end else if ((opd1_q.exp == 8'h00) || (opd2_q.exp == 8'h00)) begin
      norm_res = fp_special(res_sign, 1'b0);
    end else if (exp_rnd >= $signed(10'(FP_EXP_MAX))) begin
      norm_res = fp_special(res_sign, 1'b1);
      norm_ovf = 1'b1;
    end else if (exp_rnd <= 10'sd0) begin
      norm_res = fp_special(res_sign, 1'b0);
      norm_unf = 1'b1;
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    opd1_d  = opd1_q;
    opd2_d  = opd2_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    start_d = accept;
    unique case (state_q)
      IDLE: if (accept) begin
        opd1_d  = opd1;
        opd2_d  = opd2;
        res_d   = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        state_d = MUL;
      end
      MUL:  if (mul_done) state_d = NORM;
      NORM: begin
        res_d   = norm_res;
        ovf_d   = norm_ovf;
        unf_d   = norm_unf;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    opd1_q <= opd1_d;
    opd2_q <= opd2_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: directed FP32 vectors, randomised operands, latency,
// output back-pressure and mid-operation reset.
module tb_fp_mul_seq;

  localparam int RADIX_BITS = 1;
  localparam int N          = 24 / RADIX_BITS;
  localparam int LAT        = N + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] opd1, opd2, res;
  logic        overflow, underflow;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fp_mul_seq #(.RADIX_BITS(RADIX_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opd1      (opd1),
    .opd2      (opd2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Expected entry: {overflow, underflow, res}
  logic [33:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int accept_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
  endtask

  function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    logic        g, st;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {2'b10, s, 8'hFF, 23'b0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {2'b00, s, 31'b0};
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = p[45:23]; g = p[22]; st = |p[21:0];
    end
`ifdef FP_MUL_RNE_EN
    if (g && (st || m[0])) begin
      if (m == 23'h7FFFFF) begin
        m = '0; e = e + 1;
      end else m = m + 23'd1;
    end
`else
    if (g && st) m = m;
`endif
    if (e >= 255) return {2'b10, s, 8'hFF, 23'b0};
    if (e <= 0)   return {2'b01, s, 31'b0};
    return {2'b00, s, 8'(e), m};
  endfunction

  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [33:0] e);
    bit ok = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    opd1     = a;
    opd2     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) check({tag, " accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic recv(input string tag, input int hold, input bit chk_lat);
    bit          got = 1'b0;
    logic [33:0] e;
    logic [31:0] snap;
    out_ready = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check({tag, " out_valid_timeout"}, 64'd0, 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (chk_lat) check({tag, " latency"}, 64'(cyc - accept_cyc), 64'(LAT));
    if (exp_q.size() == 0) begin
      check({tag, " unexpected_output"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " res"},   64'(res), 64'(e[31:0]));
    check({tag, " flags"}, 64'({overflow, underflow}), 64'(e[33:32]));
    snap = res;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold_state"}, 64'({out_valid, in_ready}), 64'(2'b10));
      check({tag, " hold_res"},   64'(res), 64'(snap));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " post_handshake"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [33:0] e);
    send(tag, a, b, e);
    recv(tag, 0, 1'b0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          stayed_low;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opd1      = '0;
    opd2      = '0;
    repeat (3) @(negedge clk);
    check("reset_ready_valid", 64'({in_ready, out_valid}), 64'(2'b10));
    check("reset_res_flags",   64'({overflow, underflow, res}), 64'd0);
    rst = 1'b0;

    send("t1_2x3", 32'h40000000, 32'h40400000, {2'b00, 32'h40C00000});
    recv("t1_2x3", 0, 1'b1);
    op("t2_1p5sq",   32'h3FC00000, 32'h3FC00000, {2'b00, 32'h40100000});
    op("t3_negzero", 32'hBF800000, 32'h00000000, {2'b00, 32'h80000000});
    op("t3_ovf",     32'h7F000000, 32'h40000000, {2'b10, 32'h7F800000});
`ifdef FP_MUL_RNE_EN
    op("t4_round",   32'h3FC00001, 32'h3FC00000, {2'b00, 32'h40100001});
`else
    op("t4_round",   32'h3FC00001, 32'h3FC00000, {2'b00, 32'h40100000});
`endif
    op("t5_unf",     32'h00800000, 32'h00800000, {2'b01, 32'h00000000});
    op("inf_in",     32'h7F800000, 32'h3F800000, {2'b10, 32'h7F800000});
    op("inf_x_zero", 32'hFF800000, 32'h00000000, {2'b10, 32'hFF800000});
    op("neg_prod",   32'hC0000000, 32'h40400000, {2'b00, 32'hC0C00000});

    send("t6_hold", 32'h40400000, 32'h40400000, {2'b00, 32'h41100000});
    recv("t6_hold", 3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i < 16) begin
        ra[30:23] = 8'($urandom_range(90, 165));
        rb[30:23] = 8'($urandom_range(90, 165));
      end
      op("rand", ra, rb, ref_mul(ra, rb));
    end

    send("t6_rst", 32'h40000000, 32'h40400000, {2'b00, 32'h40C00000});
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_state", 64'({out_valid, in_ready}), 64'(2'b01));
    rst = 1'b0;
    exp_q.delete();
    stayed_low = 1'b1;
    repeat (LAT + 6) begin
      @(negedge clk);
      if (out_valid) stayed_low = 1'b0;
    end
    check("t6_rst_discard", 64'(stayed_low), 64'd1);
    send("t6_after_rst", 32'h3FC00000, 32'h40000000, {2'b00, 32'h40400000});
    recv("t6_after_rst", 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
